// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and alu_share_arbiter.
// One shared result/zero pair serves both response channels.
interface alu_share_arbiter_if #(parameter int N = 64);
  logic         req0_valid;
  logic         req0_ready;
  logic [2:0]   req0_func;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [2:0]   req1_func;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         rsp0_valid;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_zero;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds valid and payload stable until that edge.
  modport master (
    output req0_valid, req0_func, req0_a, req0_b,
    output req1_valid, req1_func, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_func, req0_a, req0_b,
    input  req1_valid, req1_func, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external ripple ALU between two requesters.
// IDLE accepts a request, EXEC samples the ALU, RESP holds the response.
module alu_share_arbiter #(
  parameter int N = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus,
  output logic                 alu_ainvert,
  output logic                 alu_binvert,
  output logic                 alu_cin,
  output logic [1:0]           alu_op,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  input  logic [N-1:0]         alu_result,
  input  logic                 alu_zero,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       owner;
  logic       last_grant;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       win;
  logic [2:0] func_sel;
  logic [4:0] ctrl;

  // {ainvert, binvert, cin, op}; reserved codes fall through to ADD.
  function automatic logic [4:0] decode(input logic [2:0] func);
    case (func)
      3'b000:  decode = 5'b000_00;
      3'b001:  decode = 5'b000_01;
      3'b011:  decode = 5'b011_10;
      3'b100:  decode = 5'b110_00;
      default: decode = 5'b000_10;
    endcase
  endfunction

  // A tie goes to whichever requester was not served last.
  assign grant0   = bus.req0_valid && (!bus.req1_valid || last_grant);
  assign grant1   = bus.req1_valid && (!bus.req0_valid || !last_grant);
  assign func_sel = win ? bus.req1_func : bus.req0_func;
  assign ctrl     = decode(func_sel);
  assign state_dbg = state;

  always_comb begin
    state_next     = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    accept         = 1'b0;
    win            = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        accept         = grant0 || grant1;
        win            = grant1;
        if (accept) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        bus.rsp0_valid = !owner;
        bus.rsp1_valid = owner;
        if (owner ? bus.rsp1_ready : bus.rsp0_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      alu_ainvert    <= 1'b0;
      alu_binvert    <= 1'b0;
      alu_cin        <= 1'b0;
      alu_op         <= 2'b00;
      alu_a          <= '0;
      alu_b          <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner       <= win;
        alu_a       <= win ? bus.req1_a : bus.req0_a;
        alu_b       <= win ? bus.req1_b : bus.req0_b;
        alu_ainvert <= ctrl[4];
        alu_binvert <= ctrl[3];
        alu_cin     <= ctrl[2];
        alu_op      <= ctrl[1:0];
      end
      if (state == EXEC) begin
        bus.rsp_result <= alu_result;
        bus.rsp_zero   <= alu_zero;
        last_grant     <= owner;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ripple ALU model
// attached to the alu_* ports.
module tb_alu_share_arbiter;
  localparam int N = 64;
  localparam logic [2:0] F_AND = 3'b000, F_OR = 3'b001, F_ADD = 3'b010,
                         F_SUB = 3'b011, F_NOR = 3'b100, F_RSV = 3'b111;

  logic         clk;
  logic         rst_n;
  logic         alu_ainvert, alu_binvert, alu_cin;
  logic [1:0]   alu_op;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero;
  logic [1:0]   state_dbg;
  logic [N-1:0] la, lb;

  int n_checks = 0;
  int n_pass   = 0;
  logic [N:0] exp_q[$];

  alu_share_arbiter_if #(.N(N)) bus ();

  alu_share_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .alu_ainvert (alu_ainvert),
    .alu_binvert (alu_binvert),
    .alu_cin     (alu_cin),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external ALU model
  always_comb begin
    la = alu_ainvert ? ~alu_a : alu_a;
    lb = alu_binvert ? ~alu_b : alu_b;
    case (alu_op)
      2'b00:   alu_result = la & lb;
      2'b01:   alu_result = la | lb;
      2'b10:   alu_result = la + lb + N'(alu_cin);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // driver tasks
  task automatic set_req(input int r, input logic v, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] b);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_func = f; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_func = f; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic set_rsp_ready(input int r, input logic v);
    if (r == 0) bus.rsp0_ready = v;
    else        bus.rsp1_ready = v;
  endtask

  // Starts at a negedge in IDLE with the other requester idle.
  task automatic run_op(input int r, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] exp_ctrl,
                        input logic [63:0] exp_res, input logic exp_zero,
                        input string tag);
    logic [N:0] e;
    exp_q.push_back({exp_zero, exp_res});
    set_req(r, 1'b1, f, a, b);
    #1;
    check({tag, "_req_ready"}, 64'((r == 0) ? bus.req0_ready : bus.req1_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(r, 1'b0, 3'd0, 64'd0, 64'd0);
    check({tag, "_exec_state"}, 64'(state_dbg), 64'd1);
    check({tag, "_ctrl"}, 64'({alu_ainvert, alu_binvert, alu_cin, alu_op}), 64'(exp_ctrl));
    check({tag, "_alu_b"}, alu_b, b);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, "_rsp_valid"}, 64'((r == 0) ? bus.rsp0_valid : bus.rsp1_valid), 64'd1);
    check({tag, "_rsp_other"}, 64'((r == 0) ? bus.rsp1_valid : bus.rsp0_valid), 64'd0);
    check({tag, "_result"}, bus.rsp_result, e[N-1:0]);
    check({tag, "_zero"}, 64'(bus.rsp_zero), 64'(e[N]));
    set_rsp_ready(r, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rsp_ready(r, 1'b0);
    check({tag, "_back_idle"}, 64'(state_dbg), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
    set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_result", bus.rsp_result, 64'd0);
    check("rst_zero", 64'(bus.rsp_zero), 64'd0);
    check("rst_rsp_valid", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    check("rst_alu_ctrl", 64'({alu_ainvert, alu_binvert, alu_cin, alu_op}), 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // function coverage, zero flag, wrap-around
    run_op(0, F_ADD, 64'd5, 64'd7, 5'b00010, 64'd12, 1'b0, "add");
    run_op(1, F_SUB, 64'h1234, 64'h1234, 5'b01110, 64'd0, 1'b1, "sub_zero");
    run_op(0, F_ADD, '1, 64'd1, 5'b00010, 64'd0, 1'b1, "add_wrap");
    run_op(1, F_NOR, 64'd0, 64'd0, 5'b11000, '1, 1'b0, "nor");
    run_op(0, F_AND, 64'hF0F0, 64'hFF00, 5'b00000, 64'hF000, 1'b0, "and");
    run_op(1, F_OR, 64'h0F0F, 64'hF000, 5'b00001, 64'hFF0F, 1'b0, "or");
    run_op(0, F_SUB, 64'd3, 64'd5, 5'b01110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "sub_neg");
    run_op(1, F_RSV, 64'd3, 64'd4, 5'b00010, 64'd7, 1'b0, "rsv");
    for (int i = 0; i < 3; i++)
      run_op(1, F_ADD, 64'(i), 64'd10, 5'b00010, 64'(i + 10), 1'b0, "req1_only");

    // alternation under a continuous tie from reset
    do_reset();
    set_req(0, 1'b1, F_ADD, 64'd1, 64'd1);
    set_req(1, 1'b1, F_OR, 64'hF0, 64'h0F);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("arb_ready0", 64'(bus.req0_ready), 64'(i % 2 == 0));
      check("arb_ready1", 64'(bus.req1_ready), 64'(i % 2 == 1));
      @(posedge clk);
      @(negedge clk);
      check("arb_exec_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
      @(negedge clk);
      check("arb_rsp0_valid", 64'(bus.rsp0_valid), 64'(i % 2 == 0));
      check("arb_result", bus.rsp_result, (i % 2 == 0) ? 64'd2 : 64'hFF);
      @(negedge clk);
    end
    set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
    set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // backpressure on rsp0 while req1 waits
    set_req(0, 1'b1, F_AND, 64'hFF, 64'h0F);
    #1;
    check("bp_accept0", 64'(bus.req0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
    set_req(1, 1'b1, F_SUB, 64'd10, 64'd3);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.rsp1_ready = 1'b1;
      #1;
      check("bp_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
      check("bp_result", bus.rsp_result, 64'h0F);
      check("bp_req1_ready", 64'(bus.req1_ready), 64'd0);
      @(negedge clk);
    end
    bus.rsp1_ready = 1'b0;
    bus.rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    check("bp_req1_after", 64'(bus.req1_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
    @(negedge clk);
    check("bp_rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
    check("bp_rsp1_result", bus.rsp_result, 64'd7);
    bus.rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp1_ready = 1'b0;

    // req0 served last, then reset in EXEC must restore the tie to req0
    run_op(0, F_ADD, 64'd1, 64'd2, 5'b00010, 64'd3, 1'b0, "pre_rst");
    set_req(1, 1'b1, F_ADD, 64'd2, 64'd2);
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
    check("mid_exec_state", 64'(state_dbg), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 64'(state_dbg), 64'd0);
    check("mid_rst_result", bus.rsp_result, 64'd0);
    check("mid_rst_alu_a", alu_a, 64'd0);
    check("mid_rst_rsp_valid", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    end
    bus.rsp1_ready = 1'b0;
    set_req(0, 1'b1, F_ADD, 64'd0, 64'd0);
    set_req(1, 1'b1, F_ADD, 64'd0, 64'd0);
    #1;
    check("post_rst_tie0", 64'(bus.req0_ready), 64'd1);
    check("post_rst_tie1", 64'(bus.req1_ready), 64'd0);
    set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
    set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates one shared N-bit ripple ALU between two requesters: requester 0 (branch-compare path) and requester 1 (address/PC path). It accepts one operation at a time through a valid/ready handshake and picks the next requester round-robin. It translates a 3-bit function code into the ALU's Ainvert/Binvert/Cin/Op controls, registers the operands, and registers result and zero. It returns them on a per-requester response channel that supports backpressure. The ALU instance sits outside this block; this block drives its inputs and samples its outputs.

## Interface
- N, 64, datapath width; must match the attached ALU.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid, req1_valid  in  1  request present.
- req0_ready, req1_ready  out  1  request accepted this cycle when ready and valid are both high.
- req0_func, req1_func  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101–111 reserved (executed as ADD).
- req0_a, req0_b, req1_a, req1_b  in  N  operands.
- rsp0_valid, rsp1_valid  out  1  response present.
- rsp0_ready, rsp1_ready  in  1  response consumed.
- rsp_result  out  N  registered ALU result, shared by both response channels.
- rsp_zero  out  1  registered ALU zero flag.
- alu_ainvert, alu_binvert, alu_cin  out  1  ALU controls.
- alu_op  out  2  ALU operation select.
- alu_a, alu_b  out  N  ALU operands.
- alu_result  in  N  combinational ALU result.
- alu_zero  in  1  ALU zero flag; high when the result is all-zero.

## Operation
- States:
  - IDLE: waits for a request; arbitrates when either requester is valid.
  - EXEC: the ALU evaluates the registered operands and controls.
  - RESP: holds the response until it is consumed.
- IDLE arbitration:
  - Exactly one of req0_ready/req1_ready may be high: the winner, and only if it is valid.
  - Winner rule: if only one requester is valid, it wins. If both are valid, the requester not served last wins (last_grant register).
  - On acceptance, the block registers a, b, and the func-derived controls, records owner = winner, and moves to EXEC.
- Function decode, given as {ainvert, binvert, cin, op}:
  - AND = 0,0,0,00
  - OR = 0,0,0,01
  - ADD = 0,0,0,10
  - SUB = 0,1,1,10
  - NOR = 1,1,0,00
  - Reserved codes decode as ADD.
- EXEC: rsp_result ← alu_result, rsp_zero ← alu_zero, last_grant ← owner, then move to RESP.
- RESP:
  - rsp<owner>_valid is high; the other response valid stays low.
  - On rsp<owner>_ready, move to IDLE.
  - Both req_ready outputs are low in EXEC and RESP.
- Arithmetic:
  - Arithmetic is modulo 2^N; carry-out is not exported.
  - SUB is a + ~b + 1.
  - rsp_zero reflects the full N-bit result for every function.
- Operand, control, and rsp registers hold their values outside the capture cycles. The ALU inputs therefore stay stable through RESP.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All req_ready/rsp_valid = 0.
  - rsp_result = 0, rsp_zero = 0.
  - alu_* controls and operands = 0.
- Latency: accept on edge T, EXEC during cycle T+1, rsp_valid high in cycle T+2. Minimum 3 cycles per operation when rsp_ready is held high.
- A response handshake in RESP returns to IDLE. A new request may be accepted in the IDLE cycle that follows.
- req_ready is combinational from the req_valid inputs and state; it has no dependency on the response channel.
- A requester must hold valid, func, and operands stable until accepted; dropping valid before acceptance is allowed.
- Backpressure: RESP persists indefinitely. rsp_result, rsp_zero, and rsp_valid stay stable, and no request is accepted.
- Reset during EXEC or RESP discards the operation: no response is issued, and the owner must re-request.
- A ready asserted on a non-owner response channel is ignored.

## Test plan
- Single request: req0 ADD a=5, b=7 → req0_ready in the accept cycle; rsp0_valid 2 cycles later with rsp_result=12 and rsp_zero=0; rsp1_valid stays 0.
- Zero flag and wrap-around:
  - req1 SUB a=b=0x1234 → rsp_result=0, rsp_zero=1.
  - ADD a=all-ones, b=1 → rsp_result=0, rsp_zero=1.
  - NOR a=b=0 → rsp_result=all-ones.
- Arbitration:
  - Both valid continuously after reset → grants alternate 0,1,0,1 over 4 operations.
  - With only req1 valid, repeated grants go to req1.
- Backpressure: hold rsp0_ready low for 5 cycles with req1 valid → rsp0_valid and rsp_result stay stable and req1_ready stays 0. After release, req1 is accepted in the next IDLE cycle.
- Reserved func 111 with a=3, b=4 → result 7 (ADD); alu_binvert=0, alu_cin=0, alu_op=10.
- Reset mid-EXEC: assert rst_n low for 1 cycle → all outputs go to reset values, no rsp_valid appears, and a subsequent tie is granted to req0.
